// File: rtl/wash_pkg.sv
// Shared state, mode and timing definitions for the wash cycle sequencer.
// Timing defaults are overridable through the top-level parameters.
package wash_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_HEAT  = 3'd2,
    S_WASH  = 3'd3,
    S_DRAIN = 3'd4,
    S_SPIN  = 3'd5,
    S_DONE  = 3'd6,
    S_FAULT = 3'd7
  } wash_state_e;

  localparam logic [3:0] M_COTTON     = 4'd0;
  localparam logic [3:0] M_SYNTHETIC  = 4'd1;
  localparam logic [3:0] M_MIXED      = 4'd2;
  localparam logic [3:0] M_QUICK_WASH = 4'd3;
  localparam logic [3:0] M_SPORTS     = 4'd4;
  localparam logic [3:0] M_DELICATES  = 4'd5;
  localparam logic [3:0] M_WOOL       = 4'd6;
  localparam logic [3:0] M_COLOURS    = 4'd7;

  localparam int FILL_TIMEOUT_D = 60;
  localparam int HEAT_TIMEOUT_D = 120;
  localparam int WASH_TIME_D    = 30;
  localparam int SPIN_TIME_D    = 15;
  localparam int HYST_D         = 2;

  function automatic logic is_active(
    input wash_state_e s
  );
    return (s == S_FILL) || (s == S_HEAT) ||
           (s == S_WASH) || (s == S_DRAIN) ||
           (s == S_SPIN);
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Per-phase tick_1s counter: synchronous clear, freeze, saturates at 255.
// Clear takes priority so a tick on the entry edge never leaks into the new phase.
module wash_phase_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       tick,
  input  logic       freeze,
  output logic [7:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (tick && !freeze && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Washing machine cycle sequencer: FILL/HEAT/WASH/DRAIN/SPIN with timeouts.
// Define WASH_SEQ_PAUSE_EN to add the pause input and hold logic.
module wash_cycle_sequencer
  import wash_pkg::*;
#(
  parameter int FILL_TIMEOUT = FILL_TIMEOUT_D,
  parameter int HEAT_TIMEOUT = HEAT_TIMEOUT_D,
  parameter int WASH_TIME    = WASH_TIME_D,
  parameter int SPIN_TIME    = SPIN_TIME_D,
  parameter int HYST         = HYST_D
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] wash_mode,
  input  logic [6:0] target_temp,
  input  logic [6:0] water_temp,
  input  logic       water_full,
  input  logic       water_empty,
  input  logic       tick_1s,
`ifdef WASH_SEQ_PAUSE_EN
  input  logic       pause,
`endif
  output logic       door_lock,
  output logic       fill_valve,
  output logic       heater_on,
  output logic       motor_wash,
  output logic       motor_spin,
  output logic       drain_pump,
  output logic [2:0] phase,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [7:0] FILL_LIM = 8'(FILL_TIMEOUT);
  localparam logic [7:0] HEAT_LIM = 8'(HEAT_TIMEOUT);
  localparam logic [7:0] WASH_LIM = 8'(WASH_TIME);
  localparam logic [7:0] SPIN_LIM = 8'(SPIN_TIME);
  localparam logic [6:0] HYST_V   = 7'(HYST);

  wash_state_e state;
  wash_state_e state_nxt;
  logic        start_q;
  logic        start_edge;
  logic [3:0]  mode_q;
  logic [6:0]  tgt_q;
  logic [6:0]  heat_lo;
  logic [7:0]  count;
  logic [7:0]  limit;
  logic        expired;
  logic        hold;
  logic        heat_nxt;

  assign start_edge = start & ~start_q;
  assign phase      = state;

`ifdef WASH_SEQ_PAUSE_EN
  assign hold = pause & is_active(state);
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    limit = 8'hFF;
    unique case (1'b1)
      (state == S_FILL),
      (state == S_DRAIN): limit = FILL_LIM;
      (state == S_HEAT):  limit = HEAT_LIM;
      (state == S_WASH):  limit = WASH_LIM;
      (state == S_SPIN):  limit = SPIN_LIM;
      default:            limit = 8'hFF;
    endcase
  end

  assign expired = (count >= limit);

  // Sensor conditions are tested before expiry so they win a tie.
  always_comb begin
    state_nxt = state;
    if (!hold) begin
      unique case (state)
        S_IDLE:
          if (start_edge && !wash_mode[3])
            state_nxt = S_FILL;
        S_FILL:
          if (water_full)
            state_nxt = (mode_q == M_QUICK_WASH) ?
                        S_WASH : S_HEAT;
          else if (expired)
            state_nxt = S_FAULT;
        S_HEAT:
          if (water_temp >= tgt_q)
            state_nxt = S_WASH;
          else if (expired)
            state_nxt = S_FAULT;
        S_WASH:
          if (expired)
            state_nxt = S_DRAIN;
        S_DRAIN:
          if (water_empty)
            state_nxt = (mode_q == M_DELICATES ||
                         mode_q == M_WOOL) ?
                        S_DONE : S_SPIN;
          else if (expired)
            state_nxt = S_FAULT;
        S_SPIN:
          if (expired)
            state_nxt = S_DONE;
        S_DONE:
          state_nxt = S_IDLE;
        S_FAULT:
          if (start_edge)
            state_nxt = S_IDLE;
      endcase
    end
  end

  assign heat_lo = (tgt_q > HYST_V) ? (tgt_q - HYST_V) : 7'd0;

  always_comb begin
    heat_nxt = 1'b0;
    if (!hold) begin
      if (state_nxt == S_HEAT) begin
        heat_nxt = (water_temp < tgt_q);
      end else if (state_nxt == S_WASH) begin
        if (water_temp < heat_lo)
          heat_nxt = 1'b1;
        else if (water_temp >= tgt_q)
          heat_nxt = 1'b0;
        else
          heat_nxt = heater_on;
      end
    end
  end

  wash_phase_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_nxt != state),
    .tick    (tick_1s),
    .freeze  (hold),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      mode_q     <= 4'd0;
      tgt_q      <= 7'd0;
      door_lock  <= 1'b0;
      busy       <= 1'b0;
      fill_valve <= 1'b0;
      heater_on  <= 1'b0;
      motor_wash <= 1'b0;
      motor_spin <= 1'b0;
      drain_pump <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      if (state == S_IDLE && state_nxt == S_FILL) begin
        mode_q <= wash_mode;
        tgt_q  <= target_temp;
      end
      door_lock  <= is_active(state_nxt);
      busy       <= is_active(state_nxt);
      fill_valve <= (state_nxt == S_FILL) && !hold;
      heater_on  <= heat_nxt;
      motor_wash <= (state_nxt == S_WASH) && !hold;
      motor_spin <= (state_nxt == S_SPIN) && !hold;
      drain_pump <= (state_nxt == S_DRAIN ||
                     state_nxt == S_SPIN) && !hold;
      done       <= (state_nxt == S_DONE);
      error      <= (state_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Bench for wash_cycle_sequencer: directed tables, hand sequences and
// random traffic checked against a phase-level reference model.
module tb_wash_cycle_sequencer;

  localparam int FT = 60;
  localparam int HT = 120;
  localparam int WT = 30;
  localparam int ST = 15;
  localparam int HY = 2;
`ifdef WASH_SEQ_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] wash_mode = 4'd0;
  logic [6:0] target_temp = 7'd0;
  logic [6:0] water_temp = 7'd20;
  logic       water_full = 1'b0;
  logic       water_empty = 1'b0;
  logic       tick_1s = 1'b0;
  logic       pause_v = 1'b0;
  logic       door_lock, fill_valve, heater_on;
  logic       motor_wash, motor_spin, drain_pump;
  logic [2:0] phase;
  logic       busy, done, error;

  always #5 clk = ~clk;

  wash_cycle_sequencer #(
    .FILL_TIMEOUT(FT), .HEAT_TIMEOUT(HT),
    .WASH_TIME(WT), .SPIN_TIME(ST), .HYST(HY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .wash_mode(wash_mode), .target_temp(target_temp),
    .water_temp(water_temp), .water_full(water_full),
    .water_empty(water_empty), .tick_1s(tick_1s),
`ifdef WASH_SEQ_PAUSE_EN
    .pause(pause_v),
`endif
    .door_lock(door_lock), .fill_valve(fill_valve),
    .heater_on(heater_on), .motor_wash(motor_wash),
    .motor_spin(motor_spin), .drain_pump(drain_pump),
    .phase(phase), .busy(busy), .done(done), .error(error)
  );

  int checks = 0;
  int errors = 0;
  int ncyc = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Reference model: phase number, seconds elapsed in phase, latched job.
  int m_ph, m_cnt, m_mode, m_tgt;
  bit m_sq, m_heat, m_hold;

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_mode = 0; m_tgt = 0;
    m_sq = 0; m_heat = 0; m_hold = 0;
  endtask

  function automatic int lim(input int ph);
    case (ph)
      1, 4:    return FT;
      2:       return HT;
      3:       return WT;
      5:       return ST;
      default: return 100000;
    endcase
  endfunction

  task automatic model_edge();
    bit ed, act, hold, expd;
    int nph, lo;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ed   = start && !m_sq;
    m_sq = start;
    act  = (m_ph >= 1 && m_ph <= 5);
    hold = PAUSE_ON && pause_v && act;
    expd = (m_cnt >= lim(m_ph));
    nph  = m_ph;
    if (!hold) begin
      case (m_ph)
        0: if (ed && wash_mode < 8) nph = 1;
        1: if (water_full) nph = (m_mode == 3) ? 3 : 2;
           else if (expd) nph = 7;
        2: if (water_temp >= m_tgt) nph = 3;
           else if (expd) nph = 7;
        3: if (expd) nph = 4;
        4: if (water_empty) nph = (m_mode == 5 || m_mode == 6) ? 6 : 5;
           else if (expd) nph = 7;
        5: if (expd) nph = 6;
        6: nph = 0;
        default: if (ed) nph = 0;
      endcase
    end
    if (hold) m_heat = 0;
    else if (nph == 2) m_heat = (water_temp < m_tgt);
    else if (nph == 3) begin
      lo = m_tgt - HY;
      if (lo < 0) lo = 0;
      if (water_temp < lo) m_heat = 1;
      else if (water_temp >= m_tgt) m_heat = 0;
    end else m_heat = 0;
    if (m_ph == 0 && nph == 1) begin
      m_mode = int'(wash_mode);
      m_tgt  = int'(target_temp);
    end
    if (nph != m_ph) m_cnt = 0;
    else if (tick_1s && !hold && m_cnt < 255) m_cnt++;
    m_hold = hold;
    m_ph   = nph;
  endtask

  function automatic logic [11:0] exp_vec();
    bit a;
    a = (m_ph >= 1 && m_ph <= 5);
    return {a, m_ph == 1 && !m_hold, m_heat,
            m_ph == 3 && !m_hold, m_ph == 5 && !m_hold,
            (m_ph == 4 || m_ph == 5) && !m_hold,
            3'(m_ph), a, m_ph == 6, m_ph == 7};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {door_lock, fill_valve, heater_on, motor_wash,
            motor_spin, drain_pump, phase, busy, done, error};
  endfunction

  logic [7:0] vis;
  int wash_ticks, fill_ticks, done_cnt;
  bit fill_ok = 1'b1;

  task automatic clr_stats();
    vis = 8'd0; wash_ticks = 0; fill_ticks = 0; done_cnt = 0;
  endtask

  task automatic step();
    if (tick_1s && phase == 3'd3) wash_ticks++;
    if (tick_1s && phase == 3'd1) fill_ticks++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model", 32'(dut_vec()), 32'(exp_vec()));
    vis[phase] = 1'b1;
    if (done) done_cnt++;
    ncyc++;
  endtask

  task automatic tstep();
    tick_1s = (ncyc % 2 == 0);
    step();
  endtask

  task automatic run_to(input logic [2:0] ph, input string name);
    int n;
    n = 0;
    while (phase != ph && n < 3000) begin
      water_full  = (phase == 3'd1) && fill_ok;
      water_empty = (phase == 3'd4);
      if (phase == 3'd2 && water_temp < target_temp)
        water_temp = water_temp + 7'd1;
      tstep();
      n++;
    end
    water_full  = 1'b0;
    water_empty = 1'b0;
    chk(name, 32'(phase), 32'(ph));
  endtask

  task automatic launch(input logic [3:0] m, input logic [6:0] t);
    wash_mode = m; target_temp = t; water_temp = 7'd20;
    start = 1'b1;
    tstep();
    start = 1'b0;
    chk("launch_fill", 32'(phase), 32'd1);
  endtask

  typedef struct {
    logic [3:0] mode;
    logic [6:0] tgt;
    logic [7:0] vis;
  } mode_vec_t;

  typedef struct {
    logic [6:0] wt;
    logic       heat;
  } hyst_vec_t;

  mode_vec_t mt[5];
  hyst_vec_t hv[4];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mt[0] = '{4'd0, 7'd40, 8'h7F};
    mt[1] = '{4'd3, 7'd40, 8'h7B};
    mt[2] = '{4'd6, 7'd40, 8'h5F};
    mt[3] = '{4'd5, 7'd55, 8'h5F};
    mt[4] = '{4'd7, 7'd0,  8'h7F};
    hv[0] = '{7'd37, 1'b1};
    hv[1] = '{7'd39, 1'b1};
    hv[2] = '{7'd40, 1'b0};
    hv[3] = '{7'd38, 1'b0};

    model_reset();
    #1 reset_n = 1'b0;
    #1 chk("reset_outputs", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    tstep();
    reset_n = 1'b1;
    tstep();

    wash_mode = 4'd9; start = 1'b1;
    tstep();
    start = 1'b0;
    tstep();
    chk("mode9_ignored", 32'(phase), 32'd0);

    for (int i = 0; i < 5; i++) begin
      clr_stats();
      launch(mt[i].mode, mt[i].tgt);
      run_to(3'd0, "cycle_end");
      chk("phases_visited", 32'(vis), 32'(mt[i].vis));
      chk("wash_ticks", 32'(wash_ticks), 32'(WT));
      chk("done_pulse", 32'(done_cnt), 32'd1);
      chk("idle_unlock", 32'(door_lock), 32'd0);
    end

    clr_stats();
    launch(4'd0, 7'd40);
    run_to(3'd3, "hyst_wash");
    for (int i = 0; i < 4; i++) begin
      water_temp = hv[i].wt;
      tstep();
      tstep();
      chk("hyst_heater", 32'(heater_on), 32'(hv[i].heat));
    end
    run_to(3'd0, "hyst_end");

    fill_ok = 1'b0;
    clr_stats();
    launch(4'd0, 7'd40);
    run_to(3'd7, "fault_reach");
    chk("fault_ticks", 32'(fill_ticks), 32'(FT));
    chk("fault_error", 32'(error), 32'd1);
    chk("fault_act", 32'({door_lock, fill_valve, heater_on,
        motor_wash, motor_spin, drain_pump, busy}), 32'd0);
    start = 1'b1;
    tstep();
    start = 1'b0;
    chk("fault_clear_ph", 32'(phase), 32'd0);
    chk("fault_clear_err", 32'(error), 32'd0);
    tstep();
    fill_ok = 1'b1;
    launch(4'd0, 7'd40);
    run_to(3'd0, "fault_rerun");

    clr_stats();
    launch(4'd2, 7'd30);
    run_to(3'd5, "spin_reach");
    tstep();
    tstep();
    #2 reset_n = 1'b0;
    #1 chk("reset_in_spin", 32'(dut_vec()), 32'd0);
    model_reset();
    @(negedge clk);
    tstep();
    reset_n = 1'b1;
    tstep();

`ifdef WASH_SEQ_PAUSE_EN
    clr_stats();
    launch(4'd0, 7'd40);
    run_to(3'd3, "pause_wash");
    repeat (6) tstep();
    pause_v = 1'b1;
    tstep();
    chk("pause_out", 32'({door_lock, motor_wash, heater_on,
        busy}), 32'b1001);
    repeat (9) tstep();
    pause_v = 1'b0;
    run_to(3'd4, "pause_drain");
    chk("pause_wash_ticks", 32'(wash_ticks), 32'(WT + 5));
    run_to(3'd0, "pause_end");
`endif

    for (int seg = 0; seg < 12; seg++) begin
      int pf;
      pf = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 6 : 40);
      for (int i = 0; i < 500; i++) begin
        if ($urandom % 6 == 0) start = ~start;
        if ($urandom % 10 == 0) wash_mode = 4'($urandom);
        if ($urandom % 10 == 0) target_temp = 7'($urandom);
        if ($urandom % 4 == 0) water_temp = 7'($urandom);
        water_full  = (pf != 0) && ($urandom % pf == 0);
        water_empty = (pf != 0) && ($urandom % pf == 0);
        tick_1s     = 1'($urandom % 2);
        pause_v     = PAUSE_ON && ($urandom % 8 == 0);
        if ($urandom % 1500 == 0) reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/wash_cycle_sequencer.md
WASH_CYCLE_SEQUENCER -- requirements
Module: wash_cycle_sequencer

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- FILL_TIMEOUT, 60: tick_1s count allowed in FILL or DRAIN.
- HEAT_TIMEOUT, 120: tick_1s count allowed in HEAT.
- WASH_TIME, 30: tick_1s count spent in WASH.
- SPIN_TIME, 15: tick_1s count spent in SPIN.
- HYST, 2: heater hysteresis in degrees.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- reset_n, in, 1: asynchronous, active-low reset.
- start, in, 1: level input; rising edge is the command.
- wash_mode, in, 4: mode code 0..7 (COTTON..COLOURS).
- target_temp, in, 7: setpoint from the temperature selector.
- water_temp, in, 7: measured water temperature.
- water_full, in, 1: level sensor, tank full.
- water_empty, in, 1: level sensor, tank empty.
- tick_1s, in, 1: one-cycle timebase pulse.
- pause, in, 1: present only with PAUSE_EN.
- door_lock, out, 1: door lock actuator.
- fill_valve, out, 1: fill valve actuator.
- heater_on, out, 1: heater actuator.
- motor_wash, out, 1: wash motor actuator.
- motor_spin, out, 1: spin motor actuator.
- drain_pump, out, 1: drain pump actuator.
- phase, out, 3: current state code.
- busy, out, 1: cycle in progress.
- done, out, 1: one-cycle completion pulse.
- error, out, 1: fault indication.

Function
REQ-003 States and codes SHALL be: IDLE=0, FILL=1, HEAT=2, WASH=3, DRAIN=4, SPIN=5, DONE=6, FAULT=7; phase SHALL equal the state register.
REQ-004 Start edge detection SHALL use a registered copy of start; an edge is start=1 with the previous sample 0.
REQ-005 In IDLE, a start edge with wash_mode<8 SHALL latch wash_mode and target_temp and move the state to FILL. A start edge with wash_mode>=8 SHALL be ignored.
REQ-006 A start edge in any state other than IDLE or FAULT SHALL be ignored. Changes to wash_mode or target_temp after latching SHALL have no effect.
REQ-007 The phase timer SHALL:
- clear on every state entry;
- increment on tick_1s;
- saturate at 255.
A timed exit SHALL occur on the clock after the count reaches the parameter value.
REQ-008 FILL SHALL assert fill_valve. water_full SHALL move the state to HEAT, or to WASH when the latched mode is 3 (QUICK_WASH). A FILL_TIMEOUT expiry SHALL move the state to FAULT. If both occur in the same cycle, water_full SHALL win.
REQ-009 HEAT SHALL behave as follows:
- heater_on = (water_temp < latched target).
- water_temp >= target SHALL move the state to WASH.
- A HEAT_TIMEOUT expiry SHALL move the state to FAULT.
- If the temperature condition and the timeout coincide, the temperature condition SHALL win.
- target 0 SHALL exit HEAT on the next cycle.
REQ-010 WASH SHALL assert motor_wash and hold heater_on under hysteresis:
- set when water_temp < target-HYST, with the subtraction saturating at 0;
- clear when water_temp >= target;
- otherwise held.
The state SHALL move to DRAIN after WASH_TIME ticks.
REQ-011 DRAIN SHALL assert drain_pump. water_empty SHALL move the state to SPIN, or to DONE when the latched mode is 5 or 6 (DELICATES, WOOL). A FILL_TIMEOUT expiry SHALL move the state to FAULT, with water_empty taking priority.
REQ-012 SPIN SHALL assert motor_spin and drain_pump, and SHALL move the state to DONE after SPIN_TIME ticks.
REQ-013 DONE SHALL assert done for exactly one cycle, then move the state to IDLE.
REQ-014 FAULT SHALL drive all actuators off and error=1. A start edge in FAULT SHALL return the state to IDLE and clear error; that edge SHALL NOT start a new cycle.
REQ-015 door_lock and busy SHALL be 1 in FILL, HEAT, WASH, DRAIN and SPIN, and 0 otherwise. heater_on SHALL be 0 outside HEAT and WASH.
REQ-016 Outputs SHALL be decoded from registered state. heater_on SHALL be a register. No output SHALL depend combinationally on an input.

Reset
REQ-017 When reset_n=0, the block SHALL asynchronously set:
- state to IDLE;
- timer to 0;
- latched mode and target to 0;
- the start-edge register to 0;
- all outputs to 0.
REQ-018 Reset asserted mid-cycle SHALL immediately de-energise all actuators and release door_lock.

Configuration
REQ-019 Macro WASH_SEQ_PAUSE_EN SHALL control the pause feature:
- Defined: the pause port SHALL exist. pause=1 in FILL, HEAT, WASH, DRAIN or SPIN SHALL hold the state, freeze the timer and force all actuators off except door_lock=1. On pause=0, the block SHALL resume the same state with the timer value retained.
- Undefined: the pause port and all pause logic SHALL be absent.

Structure
REQ-020 Package wash_pkg SHALL hold the state enum, the mode codes (COTTON=0 .. COLOURS=7), and the default timing constants.
REQ-021 Sub-module wash_phase_timer SHALL implement the 8-bit tick counter with clear, freeze and saturation.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- COTTON (mode 0), target 40, water_temp ramping 20->40: FILL -> HEAT -> WASH (30 ticks) -> DRAIN -> SPIN (15 ticks) -> DONE; done pulse of 1 cycle; door_lock low in IDLE.
- QUICK_WASH (mode 3): HEAT skipped. WOOL (mode 6): SPIN skipped, DRAIN -> DONE.
- water_full never asserted: FAULT after 60 ticks, error=1, all actuators 0. Start edge: back to IDLE with error=0, then a second start edge begins FILL.
- WASH, target 40, HYST 2: water_temp 37 sets heater_on, 39 keeps it set, 40 clears it, 38 keeps it clear.
- reset_n low during SPIN: all outputs 0 and phase=0 in the same cycle. With WASH_SEQ_PAUSE_EN, pause for 5 ticks in WASH extends the WASH phase to 35 total ticks.
